// File: rtl/alu_exec_unit_if.sv
// Bus between the MIPS execute stage and its neighbours: operands and control in,
// decoded operation code plus registered ALU results and flags out.
interface alu_exec_unit_if;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        branch;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        branch_taken;

    modport master (
        output alu_op, funct, a, b, branch,
        input  alu_ctrl, result, zero, overflow, branch_taken
    );

    modport slave (
        input  alu_op, funct, a, b, branch,
        output alu_ctrl, result, zero, overflow, branch_taken
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-cycle MIPS execute stage: ALU-control decode, 32-bit ALU and the branch
// qualifier, with result and flags registered together every cycle.
module alu_exec_unit (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus_io
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100,
        OP_INV = 4'b1111
    } alu_ctrl_e;

    alu_ctrl_e   ctrl;
    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        overflow_d, overflow_q;
    logic        branch_taken_d, branch_taken_q;

    always_comb begin
        ctrl = OP_INV;
        unique case (bus_io.alu_op)
            2'b00: ctrl = OP_ADD;
            2'b01: ctrl = OP_SUB;
            2'b10: begin
                case (bus_io.funct)
                    6'b100000: ctrl = OP_ADD;
                    6'b100010: ctrl = OP_SUB;
                    6'b100100: ctrl = OP_AND;
                    6'b100101: ctrl = OP_OR;
                    6'b101010: ctrl = OP_SLT;
                    6'b100111: ctrl = OP_NOR;
                    default:   ctrl = OP_INV;
                endcase
            end
            default: ctrl = OP_INV;
        endcase
    end

    assign bus_io.alu_ctrl = ctrl;

    assign sum  = bus_io.a + bus_io.b;
    assign diff = bus_io.a - bus_io.b;

    // SLT compares signed operands directly so a wrapped difference cannot flip it.
    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        case (ctrl)
            OP_AND: result_d = bus_io.a & bus_io.b;
            OP_OR:  result_d = bus_io.a | bus_io.b;
            OP_ADD: begin
                result_d   = sum;
                overflow_d = (bus_io.a[31] == bus_io.b[31]) && (sum[31] != bus_io.a[31]);
            end
            OP_SUB: begin
                result_d   = diff;
                overflow_d = (bus_io.a[31] != bus_io.b[31]) && (diff[31] != bus_io.a[31]);
            end
            OP_SLT: result_d = ($signed(bus_io.a) < $signed(bus_io.b)) ? 32'd1 : 32'd0;
            OP_NOR: result_d = ~(bus_io.a | bus_io.b);
            default: begin
                result_d   = '0;
                overflow_d = 1'b0;
            end
        endcase
    end

    assign zero_d         = (result_d == 32'd0);
    assign branch_taken_d = bus_io.branch & zero_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q       <= '0;
            zero_q         <= 1'b0;
            overflow_q     <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            result_q       <= result_d;
            zero_q         <= zero_d;
            overflow_q     <= overflow_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    assign bus_io.result       = result_q;
    assign bus_io.zero         = zero_q;
    assign bus_io.overflow     = overflow_q;
    assign bus_io.branch_taken = branch_taken_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: decode, ALU functions, flags,
// branch qualification and asynchronous reset behaviour.
module tb_alu_exec_unit;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives one operation, checks the combinational decode, then the registered outputs after one edge.
    task automatic applyStimulus(
        input string       tag,
        input logic [1:0]  op,
        input logic [5:0]  fn,
        input logic [31:0] opA,
        input logic [31:0] opB,
        input logic        br,
        input logic [3:0]  expCtrl,
        input logic [31:0] expResult,
        input logic        expZero,
        input logic        expOvf,
        input logic        expTaken
    );
        bus.alu_op = op;
        bus.funct  = fn;
        bus.a      = opA;
        bus.b      = opB;
        bus.branch = br;
        #1;
        checkOutput({tag, ".ctrl"}, {28'd0, bus.alu_ctrl}, {28'd0, expCtrl});
        @(posedge clk);
        #1;
        checkOutput({tag, ".result"}, bus.result, expResult);
        checkOutput({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, expZero});
        checkOutput({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, expOvf});
        checkOutput({tag, ".taken"}, {31'd0, bus.branch_taken}, {31'd0, expTaken});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".result"}, bus.result, 32'd0);
        checkOutput({tag, ".zero"}, {31'd0, bus.zero}, 32'd0);
        checkOutput({tag, ".ovf"}, {31'd0, bus.overflow}, 32'd0);
        checkOutput({tag, ".taken"}, {31'd0, bus.branch_taken}, 32'd0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst        = 1'b1;
        bus.alu_op = 2'b00;
        bus.funct  = 6'd0;
        bus.a      = 32'd0;
        bus.b      = 32'd0;
        bus.branch = 1'b0;

        #12;
        checkResetState("por");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // R-type arithmetic
        applyStimulus("add", 2'b10, 6'b100000, 32'd5, 32'd3, 1'b0, 4'b0010, 32'd8, 1'b0, 1'b0, 1'b0);
        applyStimulus("sub", 2'b10, 6'b100010, 32'd3, 32'd5, 1'b0, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

        // Logic and SLT
        applyStimulus("and", 2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'b0000, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
        applyStimulus("or",  2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
        applyStimulus("nor", 2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 4'b1100, 32'h000F000F, 1'b0, 1'b0, 1'b0);
        applyStimulus("sltNeg", 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 1'b0, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("sltPos", 2'b10, 6'b101010, 32'd1, 32'hFFFFFFFF, 1'b0, 4'b0111, 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus("sltWrap", 2'b10, 6'b101010, 32'h80000000, 32'd1, 1'b0, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0);

        // Branch qualification
        applyStimulus("beqEq", 2'b01, 6'b000000, 32'd7, 32'd7, 1'b1, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus("beqNe", 2'b01, 6'b000000, 32'd7, 32'd8, 1'b1, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus("noBr",  2'b01, 6'b000000, 32'd7, 32'd7, 1'b0, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0);

        // Overflow and wrap-around
        applyStimulus("addOvf", 2'b10, 6'b100000, 32'h7FFFFFFF, 32'd1, 1'b0, 4'b0010, 32'h80000000, 1'b0, 1'b1, 1'b0);
        applyStimulus("subOvf", 2'b10, 6'b100010, 32'h80000000, 32'd1, 1'b0, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        applyStimulus("addWrap", 2'b00, 6'b111111, 32'hFFFFFFFF, 32'd1, 1'b0, 4'b0010, 32'd0, 1'b1, 1'b0, 1'b0);

        // Invalid decode still yields zero=1, and branch is a pure AND with it
        applyStimulus("invFn", 2'b10, 6'b000000, 32'd5, 32'd3, 1'b1, 4'b1111, 32'd0, 1'b1, 1'b0, 1'b1);
        applyStimulus("invOp", 2'b11, 6'b100000, 32'h7FFFFFFF, 32'd1, 1'b0, 4'b1111, 32'd0, 1'b1, 1'b0, 1'b0);

        // Mid-stream asynchronous reset
        applyStimulus("pre", 2'b10, 6'b100000, 32'h12345670, 32'd8, 1'b0, 4'b0010, 32'h12345678, 1'b0, 1'b0, 1'b0);
        bus.a = 32'h7FFFFFFF;
        bus.b = 32'd1;
        #2;
        rst = 1'b1;
        #1;
        checkResetState("rstAsync");
        @(posedge clk);
        #1;
        checkResetState("rstHeld");
        rst = 1'b0;

        applyStimulus("post", 2'b10, 6'b100000, 32'd10, 32'd20, 1'b0, 4'b0010, 32'd30, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
